// File: rtl/uart_bus_bridge_if.sv
// uart_bus_bridge_if: signal bundle between the UART transceiver, the register bus and the bridge
//   rx_*  : received byte side (rx_data, rx_avail, rx_error in; rx_ack out of the bridge)
//   tx_*  : transmit side (tx_data, tx_wr out of the bridge; tx_busy in)
//   bus_* : 32-bit register bus (bus_req, bus_we, bus_addr, bus_wdata out; bus_rdata, bus_ack in)
//   busy  : bridge is working on a frame or response
interface uart_bus_bridge_if;
  logic [7:0] rx_data;
  logic rx_avail;
  logic rx_error;
  logic rx_ack;
  logic [7:0] tx_data;
  logic tx_wr;
  logic tx_busy;
  logic bus_req;
  logic bus_we;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic bus_ack;
  logic busy;
  modport slave (
    input rx_data, rx_avail, rx_error, tx_busy, bus_rdata, bus_ack,
    output rx_ack, tx_data, tx_wr, bus_req, bus_we, bus_addr, bus_wdata, busy
  );
  modport master (
    output rx_data, rx_avail, rx_error, tx_busy, bus_rdata, bus_ack,
    input rx_ack, tx_data, tx_wr, bus_req, bus_we, bus_addr, bus_wdata, busy
  );
endinterface

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: parses host command frames from UART bytes into single register-bus reads/writes
//   clk, reset : clock and synchronous active-high reset
//   b          : slave end of uart_bus_bridge_if (rx byte side, tx byte side, register bus, busy)
//   RX_TIMEOUT : idle clocks inside a partial frame before it is dropped
//   BUS_TIMEOUT: clocks bus_req may wait for bus_ack before a NAK is returned
module uart_bus_bridge #(
  parameter int RX_TIMEOUT = 2600000,
  parameter int BUS_TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  uart_bus_bridge_if.slave b
);
  typedef enum logic [2:0] {IDLE, ADDR_H, ADDR_L, DATA, BUS, SEND, TXH, TXL} state_t;
  state_t state_q, state_d;
  logic rx_ack_q, rx_ack_d, tx_wr_q, tx_wr_d, bus_req_q, bus_req_d, we_q, we_d, busy_q, busy_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, resp_q, resp_d, rx_tmr_q, rx_tmr_d, bus_tmr_q, bus_tmr_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] left_q, left_d;
  logic rx_st, frm_st, take, err, byt, op_ok, rx_to, bus_to, nak;
  // the !rx_ack_q guard stops a byte (or error) being taken twice while the transceiver drops its level
  assign rx_st = state_q inside {IDLE, ADDR_H, ADDR_L, DATA};
  assign frm_st = state_q inside {ADDR_H, ADDR_L, DATA};
  assign take = rx_st && !rx_ack_q && (b.rx_avail || b.rx_error);
  assign err = take && b.rx_error;
  assign byt = take && !b.rx_error;
  assign op_ok = b.rx_data == 8'h57 || b.rx_data == 8'h52;
  assign rx_to = frm_st && !take && rx_tmr_q == 32'(RX_TIMEOUT - 1);
  assign bus_to = bus_tmr_q == 32'(BUS_TIMEOUT - 1);
  assign nak = err || (state_q == IDLE && byt && !op_ok) || (state_q == BUS && !b.bus_ack && bus_to);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rx_ack_q <= 1'b0;
      tx_wr_q <= 1'b0;
      bus_req_q <= 1'b0;
      we_q <= 1'b0;
      busy_q <= 1'b0;
      tx_data_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      resp_q <= '0;
      rx_tmr_q <= '0;
      bus_tmr_q <= '0;
      cnt_q <= '0;
      left_q <= '0;
    end else begin
      state_q <= state_d;
      rx_ack_q <= rx_ack_d;
      tx_wr_q <= tx_wr_d;
      bus_req_q <= bus_req_d;
      we_q <= we_d;
      busy_q <= busy_d;
      tx_data_q <= tx_data_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      resp_q <= resp_d;
      rx_tmr_q <= rx_tmr_d;
      bus_tmr_q <= bus_tmr_d;
      cnt_q <= cnt_d;
      left_q <= left_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = err ? SEND : byt ? (op_ok ? ADDR_H : SEND) : IDLE;
      ADDR_H: state_d = err ? SEND : byt ? ADDR_L : rx_to ? IDLE : ADDR_H;
      ADDR_L: state_d = err ? SEND : byt ? (we_q ? DATA : BUS) : rx_to ? IDLE : ADDR_L;
      DATA: state_d = err ? SEND : byt ? (cnt_q == 2'd3 ? BUS : DATA) : rx_to ? IDLE : DATA;
      BUS: state_d = b.bus_ack || bus_to ? SEND : BUS;
      SEND: state_d = b.tx_busy ? SEND : TXH;
      TXH: state_d = b.tx_busy ? TXL : TXH;
      TXL: state_d = b.tx_busy ? TXL : (left_q != 3'd0 ? SEND : IDLE);
      default: state_d = IDLE;
    endcase
  end
  // resp_q holds the pending response bytes MSB first; left_q counts how many are still to go
  always_comb begin
    rx_ack_d = take;
    tx_wr_d = state_q == SEND && !b.tx_busy;
    tx_data_d = tx_wr_d ? resp_q[31:24] : tx_data_q;
    resp_d = tx_wr_d ? {resp_q[23:0], 8'h00} : resp_q;
    left_d = tx_wr_d ? left_q - 3'd1 : left_q;
    if (nak) begin
      resp_d = 32'h1500_0000;
      left_d = 3'd1;
    end else if (state_q == BUS && b.bus_ack) begin
      resp_d = we_q ? 32'h0600_0000 : b.bus_rdata;
      left_d = we_q ? 3'd1 : 3'd4;
    end
    we_d = state_q == IDLE && byt && op_ok ? b.rx_data == 8'h57 : we_q;
    addr_d = state_q == ADDR_H && byt ? {b.rx_data, addr_q[7:0]} :
             state_q == ADDR_L && byt ? {addr_q[15:8], b.rx_data} : addr_q;
    wdata_d = state_q == DATA && byt ? {wdata_q[23:0], b.rx_data} : wdata_q;
    cnt_d = state_q == ADDR_L && byt ? 2'd0 : state_q == DATA && byt ? cnt_q + 2'd1 : cnt_q;
    rx_tmr_d = frm_st && !take ? rx_tmr_q + 32'd1 : 32'd0;
    bus_tmr_d = state_q == BUS && state_d == BUS ? bus_tmr_q + 32'd1 : 32'd0;
    bus_req_d = state_d == BUS;
    busy_d = state_d != IDLE;
  end
  assign b.rx_ack = rx_ack_q;
  assign b.tx_data = tx_data_q;
  assign b.tx_wr = tx_wr_q;
  assign b.bus_req = bus_req_q;
  assign b.bus_we = we_q;
  assign b.bus_addr = addr_q;
  assign b.bus_wdata = wdata_q;
  assign b.busy = busy_q;
endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

Byte-level command responder between the UART transceiver's parallel side and an internal 32-bit register bus. Parses host command frames from received bytes, performs single bus read/write transactions, and returns ACK/NAK or read data through the transceiver's transmit port. It is the slave end of the host debug link.

## Interface
- `RX_TIMEOUT`, default 2600000: idle clocks between bytes of a partial frame before it is dropped (100 ms at 26 MHz).
- `BUS_TIMEOUT`, default 255: clocks to wait for `bus_ack` before NAK.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `rx_data` in 8: received byte from transceiver.
- `rx_avail` in 1: byte valid; level, held until acked.
- `rx_error` in 1: framing error flag; level, cleared by ack.
- `rx_ack` out 1: one-cycle consume pulse.
- `tx_data` out 8: byte to transmit.
- `tx_wr` out 1: one-cycle transmit request.
- `tx_busy` in 1: transceiver busy; rises the cycle after an accepted `tx_wr`.
- `bus_req` out 1: transaction request; level, held until ack or timeout.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 16: byte address.
- `bus_wdata` out 32: write data.
- `bus_rdata` in 32: read data, valid with `bus_ack`.
- `bus_ack` in 1: one-cycle completion.
- `busy` out 1: high in every state except IDLE.

## Operation
- Frames:
  - Write: `0x57`, ADDR[15:8], ADDR[7:0], D[31:24], D[23:16], D[15:8], D[7:0]. Response: `0x06`.
  - Read: `0x52`, ADDR[15:8], ADDR[7:0]. Response: D[31:24], D[23:16], D[15:8], D[7:0].
  - Any other opcode: response `0x15` (NAK).
  - Bus timeout: response `0x15`.
- Byte consume: a byte is taken when `rx_avail && !rx_ack`. On that cycle:
  - `rx_ack` is registered high for exactly one cycle.
  - The `!rx_ack` term prevents double-consuming while `rx_avail` falls.
- Byte acceptance by state: bytes are consumed only in IDLE, ADDR_H, ADDR_L and DATA. In every other state, pending bytes are left unacked.
- States:
  - IDLE:
    - `0x57` → ADDR_H with we=1.
    - `0x52` → ADDR_H with we=0.
    - Other opcode → SEND with a one-byte NAK.
  - ADDR_H → ADDR_L.
  - ADDR_L:
    - we=0 → BUS.
    - we=1 → DATA, byte count cleared.
  - DATA: shifts bytes into `bus_wdata` MSB first. After the 4th byte → BUS.
  - BUS:
    - Raises `bus_req` and starts the bus timer.
    - `bus_ack` with we=1 → SEND with `0x06`.
    - `bus_ack` with we=0 → captures `bus_rdata` → SEND with 4 bytes.
    - Timer reaches `BUS_TIMEOUT` → drops `bus_req` → SEND with NAK.
  - SEND:
    - When `tx_busy==0`: drives `tx_data` and pulses `tx_wr` for one cycle → TXH.
  - TXH: waits for `tx_busy==1` → TXL.
  - TXL: waits for `tx_busy==0`.
    - More bytes remain → SEND.
    - Otherwise → IDLE.
- Inter-byte timeout:
  - In ADDR_H, ADDR_L and DATA, a 32-bit timer counts cycles with no consumed byte.
  - The timer reloads on each consume.
  - Reaching `RX_TIMEOUT` → IDLE silently, no response.
- `rx_error` in any receive state (IDLE, ADDR_H, ADDR_L, DATA):
  - `rx_ack` pulses.
  - Partial frame is discarded.
  - → SEND with NAK.
  - `rx_error` has priority over `rx_avail` in the same cycle.
- Bus ordering:
  - `bus_addr`, `bus_we` and `bus_wdata` are stable for the whole time `bus_req` is high.
  - `bus_ack` outside BUS is ignored.
  - An ack arriving on the same cycle the timer expires counts as success.
- Reset mid-operation: returns to IDLE immediately. An in-flight bus request is dropped.

## Timing
- Reset values:
  - `rx_ack`, `tx_wr`, `bus_req`, `bus_we`, `busy` = 0.
  - `tx_data` = 0, `bus_addr` = 0, `bus_wdata` = 0.
  - All timers = 0.
- All outputs are registered.
- `rx_ack` is asserted the cycle after `rx_avail` is sampled high.
- Last frame byte consumed → `bus_req` high 1 cycle later.
- `bus_ack` → first `tx_wr` within 2 cycles, given `tx_busy==0`.
- Consecutive response bytes:
  - Each `tx_wr` follows a full busy high→low cycle of the previous byte.
  - `tx_wr` is never high while `tx_busy` is high.
- `busy` falls the cycle after TXL sees `tx_busy==0` on the final byte.

## Test plan
- Write: bytes 57 12 34 DE AD BE EF, bus acks 3 cycles after req.
  - `bus_we=1`, `bus_addr=0x1234`, `bus_wdata=0xDEADBEEF`.
  - Exactly one `bus_req` episode; tx emits 06.
- Read: bytes 52 00 10, `bus_rdata=0xCAFEF00D` with ack.
  - tx emits CA FE F0 0D in order, each after `tx_busy` falls.
- Opcode 0x41: tx emits 15, no `bus_req`, returns to IDLE, and a following valid read works.
- Partial frame 57 12, then silence with `RX_TIMEOUT=100`:
  - Returns to IDLE at cycle 100 after the last consume, no tx.
  - A next byte 52 starts a new frame.
- Read with no `bus_ack`, `BUS_TIMEOUT=8`: `bus_req` drops after 8 cycles, tx emits 15.
- `rx_error` during DATA byte 2: ack pulse, tx 15, no `bus_req`.
- Reset asserted during BUS: all outputs go to reset values the next cycle.
